// File: rtl/divide_controller.sv
// Sequencing controller for an attached multi-cycle signed divider:
// accepts one operand pair, strobes the divider, waits out its run, and holds the result.
module divide_controller #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [BITS-1:0] req_a,
    input  logic [BITS-1:0] req_m,
    output logic [BITS-1:0] div_a,
    output logic [BITS-1:0] div_m,
    output logic            div_start,
    input  logic [BITS-1:0] div_q,
    input  logic [BITS-1:0] div_r,
    input  logic            div_zero,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [BITS-1:0] lo,
    output logic [BITS-1:0] hi,
    output logic            exception
);

    localparam int CW = $clog2(BITS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid, once raised by the producer, holds until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] op_a;
    logic [BITS-1:0] op_m;

    assign div_a = op_a;
    assign div_m = op_m;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            cnt        <= '0;
            op_a       <= '0;
            op_m       <= '0;
            lo         <= '0;
            hi         <= '0;
            exception  <= 1'b0;
            div_start  <= 1'b0;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_a      <= req_a;
                        op_m      <= req_m;
                        state     <= LOAD;
                        req_ready <= 1'b0;
                        div_start <= 1'b1;
                    end
                end
                LOAD: begin
                    div_start <= 1'b0;
                    if (div_zero) begin
                        // Divide-by-zero skips the run; lo/hi keep the previous result.
                        state      <= DONE;
                        exception  <= 1'b1;
                        resp_valid <= 1'b1;
                    end else begin
                        state     <= RUN;
                        cnt       <= CW'(BITS - 2);
                        exception <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    lo         <= div_q;
                    hi         <= div_r;
                    state      <= DONE;
                    resp_valid <= 1'b1;
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    div_start  <= 1'b0;
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
